// File: rtl/bcd_disp_pkg.sv
// Shared types and constants for the multiplexed three-digit BCD display.
// Anode and segment values are active-low.
package bcd_disp_pkg;

    typedef enum logic [1:0] {
        S_SEC = 2'd0,
        S_MIN = 2'd1,
        S_HR  = 2'd2
    } state_t;

    localparam logic [6:0] SEG_DASH = 7'b0111111;
    localparam logic [6:0] SEG_OFF  = 7'b1111111;

    localparam logic [2:0] AN_SEC = 3'b110;
    localparam logic [2:0] AN_MIN = 3'b101;
    localparam logic [2:0] AN_HR  = 3'b011;
    localparam logic [2:0] AN_OFF = 3'b111;

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD to active-low seven-segment decoder, segment order {g,f,e,d,c,b,a}.
// Codes 10..15 are not valid BCD and show a dash.
module bcd_to_seg7
    import bcd_disp_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    always_comb begin
        unique case (bcd)
            4'd0:    seg = 7'b1000000;
            4'd1:    seg = 7'b1111001;
            4'd2:    seg = 7'b0100100;
            4'd3:    seg = 7'b0110000;
            4'd4:    seg = 7'b0011001;
            4'd5:    seg = 7'b0010010;
            4'd6:    seg = 7'b0000010;
            4'd7:    seg = 7'b1111000;
            4'd8:    seg = 7'b0000000;
            4'd9:    seg = 7'b0010000;
            default: seg = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/bcd_scan_display.sv
// Time-multiplexed driver for a three-digit (hours/minutes/seconds) BCD display.
// Digits come from a snapshot taken at frame start so a frame never mixes old and new time.
module bcd_scan_display
    import bcd_disp_pkg::*;
#(
    parameter int REFRESH_DIV = 50000,
    parameter int GUARD       = 500
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] bcd_seconds,
    input  logic [3:0] bcd_minutes,
    input  logic [3:0] bcd_hours,
    input  logic       blank,
    input  logic       dp_en,
    output logic [2:0] an,
    output logic [6:0] seg,
    output logic       dp,
    output logic       frame_done
);

    localparam int              DIV_W   = $clog2(REFRESH_DIV);
    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(REFRESH_DIV - 1);
    localparam logic [DIV_W-1:0] GUARD_V = DIV_W'(GUARD);

    logic [DIV_W-1:0] div;
    state_t           state;
    state_t           next_state;
    logic [11:0]      snap;
    logic [3:0]       digit;
    logic [2:0]       an_sel;
    logic [6:0]       seg_dec;
    logic             slot_end;
    logic             anodes_off;

    assign slot_end   = (div == DIV_MAX);
    assign anodes_off = (div < GUARD_V) || blank;

    // NOTE: every variable assigned here gets a default first so no latch is inferred.
    always_comb begin
        digit      = snap[3:0];
        an_sel     = AN_SEC;
        next_state = S_SEC;
        unique case (state)
            S_SEC: begin
                next_state = S_MIN;
            end
            S_MIN: begin
                digit      = snap[7:4];
                an_sel     = AN_MIN;
                next_state = S_HR;
            end
            S_HR: begin
                digit      = snap[11:8];
                an_sel     = AN_HR;
                next_state = S_SEC;
            end
            default: begin
                next_state = S_SEC;
            end
        endcase
    end

    bcd_to_seg7 u_dec (
        .bcd (digit),
        .seg (seg_dec)
    );

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (!rst) begin
            div        <= '0;
            state      <= S_SEC;
            snap       <= '0;
            an         <= AN_OFF;
            seg        <= SEG_OFF;
            dp         <= 1'b1;
            frame_done <= 1'b0;
        end else begin
            div <= slot_end ? '0 : div + DIV_W'(1);
            if (slot_end)
                state <= next_state;
            if (state == S_SEC && div == '0)
                snap <= {bcd_hours, bcd_minutes, bcd_seconds};
            // Segments keep decoding during the guard/blank time; only the anodes gate visibility.
            an         <= anodes_off ? AN_OFF : an_sel;
            seg        <= seg_dec;
            dp         <= ~((state == S_MIN) && dp_en && !anodes_off);
            frame_done <= (state == S_HR) && slot_end;
        end
    end

endmodule

// File: tb/tb_bcd_scan_display.sv
// Directed self-checking bench for bcd_scan_display with REFRESH_DIV=8, GUARD=2.
// A small reference model tracks cycle position and snapshot to predict each registered output.
module tb_bcd_scan_display;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] bcd_seconds, bcd_minutes, bcd_hours;
    logic       blank, dp_en;
    logic [2:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       frame_done;

    int vectors     = 0;
    int miscompares = 0;

    // reference model state
    int          m_g;
    logic [11:0] m_snap;
    logic [2:0]  e_an;
    logic [6:0]  e_seg;
    logic        e_dp;
    logic        e_fd;

    bcd_scan_display #(.REFRESH_DIV(8), .GUARD(2)) dut (
        .clk         (clk),
        .rst         (rst),
        .bcd_seconds (bcd_seconds),
        .bcd_minutes (bcd_minutes),
        .bcd_hours   (bcd_hours),
        .blank       (blank),
        .dp_en       (dp_en),
        .an          (an),
        .seg         (seg),
        .dp          (dp),
        .frame_done  (frame_done)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] seg_of(input logic [3:0] v);
        case (v)
            4'd0: return 7'b1000000;
            4'd1: return 7'b1111001;
            4'd2: return 7'b0100100;
            4'd3: return 7'b0110000;
            4'd4: return 7'b0011001;
            4'd5: return 7'b0010010;
            4'd6: return 7'b0000010;
            4'd7: return 7'b1111000;
            4'd8: return 7'b0000000;
            4'd9: return 7'b0010000;
            default: return 7'b0111111;
        endcase
    endfunction

    // Advance one clock; the model predicts outputs from the pre-edge state, then outputs are sampled 1 time unit later.
    task automatic tick();
        int         slot, d;
        logic       off;
        logic [3:0] digit;
        @(posedge clk);
        if (!rst) begin
            e_an = 3'b111; e_seg = 7'b1111111; e_dp = 1'b1; e_fd = 1'b0;
            m_g = 0; m_snap = '0;
        end else begin
            slot  = (m_g / 8) % 3;
            d     = m_g % 8;
            digit = (slot == 0) ? m_snap[3:0] : (slot == 1) ? m_snap[7:4] : m_snap[11:8];
            off   = (d < 2) || blank;
            e_an  = off ? 3'b111 : (slot == 0) ? 3'b110 : (slot == 1) ? 3'b101 : 3'b011;
            e_seg = seg_of(digit);
            e_dp  = !((slot == 1) && dp_en && !off);
            e_fd  = (slot == 2) && (d == 7);
            if (slot == 0 && d == 0)
                m_snap = {bcd_hours, bcd_minutes, bcd_seconds};
            m_g++;
        end
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        tick();
        tick();
        vectors++;
        if ({an, seg, dp, frame_done} !== {3'b111, 7'b1111111, 1'b1, 1'b0}) begin
            miscompares++;
            $display("FAIL reset_state got an=%b seg=%b dp=%b fd=%b want an=111 seg=1111111 dp=1 fd=0",
                     an, seg, dp, frame_done);
        end
    endtask

    task automatic test_scan();
        bcd_hours = 4'd1; bcd_minutes = 4'd2; bcd_seconds = 4'd3;
        rst = 1'b1;
        for (int i = 0; i < 72; i++) begin
            tick();
            vectors++;
            if ({an, seg, dp, frame_done} !== {e_an, e_seg, e_dp, e_fd}) begin
                miscompares++;
                $display("FAIL scan g=%0d got an=%b seg=%b dp=%b fd=%b want an=%b seg=%b dp=%b fd=%b",
                         m_g - 1, an, seg, dp, frame_done, e_an, e_seg, e_dp, e_fd);
            end
        end
        // frame 3, hours slot, enabled cycle
        vectors++;
        if ({an, seg} !== {3'b011, 7'b1111001}) begin
            miscompares++;
            $display("FAIL scan_hours_literal got an=%b seg=%b want an=011 seg=1111001", an, seg);
        end
    endtask

    task automatic test_tearing();
        int pos;
        for (int i = 0; i < 48; i++) begin
            if (i == 3)  bcd_hours   = 4'd5;   // during the seconds slot
            if (i == 11) bcd_seconds = 4'd4;   // during the minutes slot
            tick();
            pos = i;
            vectors++;
            if ({an, seg, dp, frame_done} !== {e_an, e_seg, e_dp, e_fd}) begin
                miscompares++;
                $display("FAIL tearing i=%0d got an=%b seg=%b fd=%b want an=%b seg=%b fd=%b",
                         i, an, seg, frame_done, e_an, e_seg, e_fd);
            end
            if (pos == 20 || pos == 44 || pos == 28) begin
                vectors++;
                if (seg !== ((pos == 20) ? 7'b1111001 : (pos == 28) ? 7'b0011001 : 7'b0010010)) begin
                    miscompares++;
                    $display("FAIL tearing_literal i=%0d got seg=%b", i, seg);
                end
            end
        end
    endtask

    task automatic test_dash();
        bcd_seconds = 4'hC;
        bcd_minutes = 4'hA;
        for (int i = 0; i < 48; i++) begin
            tick();
            vectors++;
            if ({an, seg, dp, frame_done} !== {e_an, e_seg, e_dp, e_fd}) begin
                miscompares++;
                $display("FAIL dash i=%0d got an=%b seg=%b want an=%b seg=%b", i, an, seg, e_an, e_seg);
            end
            if (i == 28 || i == 36) begin
                vectors++;
                if (seg !== 7'b0111111) begin
                    miscompares++;
                    $display("FAIL dash_literal i=%0d got seg=%b want seg=0111111", i, seg);
                end
            end
        end
        bcd_seconds = 4'd3;
        bcd_minutes = 4'd2;
    endtask

    task automatic test_dp_blank();
        int pulses = 0;
        dp_en = 1'b1;
        for (int i = 0; i < 24; i++) begin
            tick();
            vectors++;
            if ({an, dp} !== {e_an, e_dp}) begin
                miscompares++;
                $display("FAIL dp i=%0d got an=%b dp=%b want an=%b dp=%b", i, an, dp, e_an, e_dp);
            end
            if (i == 12) begin
                vectors++;
                if (dp !== 1'b0) begin
                    miscompares++;
                    $display("FAIL dp_literal got dp=%b want dp=0", dp);
                end
            end
        end
        blank = 1'b1;
        for (int i = 0; i < 48; i++) begin
            tick();
            if (frame_done === 1'b1) pulses++;
            vectors++;
            if ({an, dp, frame_done} !== {3'b111, 1'b1, e_fd}) begin
                miscompares++;
                $display("FAIL blank i=%0d got an=%b dp=%b fd=%b want an=111 dp=1 fd=%b",
                         i, an, dp, frame_done, e_fd);
            end
        end
        vectors++;
        if (pulses !== 2) begin
            miscompares++;
            $display("FAIL blank_frame_count got %0d want 2", pulses);
        end
        blank = 1'b0;
        dp_en = 1'b0;
    endtask

    task automatic test_reset_mid();
        int guard_cnt = 0;
        // position the model so the next edge sees state S_MIN with div=5
        while ((m_g % 24) != 13 && guard_cnt < 30) begin
            tick();
            guard_cnt++;
        end
        vectors++;
        if ((m_g % 24) != 13) begin
            miscompares++;
            $display("FAIL reset_mid_align got pos=%0d want 13", m_g % 24);
        end
        rst = 1'b0;
        tick();
        vectors++;
        if ({an, seg, frame_done} !== {3'b111, 7'b1111111, 1'b0}) begin
            miscompares++;
            $display("FAIL reset_mid got an=%b seg=%b fd=%b want an=111 seg=1111111 fd=0",
                     an, seg, frame_done);
        end
        rst = 1'b1;
        for (int i = 0; i < 30; i++) begin
            tick();
            vectors++;
            if ({an, seg, dp, frame_done} !== {e_an, e_seg, e_dp, e_fd}) begin
                miscompares++;
                $display("FAIL reset_restart i=%0d got an=%b seg=%b fd=%b want an=%b seg=%b fd=%b",
                         i, an, seg, frame_done, e_an, e_seg, e_fd);
            end
        end
    endtask

    task automatic test_free_run();
        int pulses = 0;
        int last   = -1;
        while ((m_g % 24) != 0) tick();
        for (int i = 0; i < 240; i++) begin
            tick();
            vectors++;
            if ({an, seg, dp, frame_done} !== {e_an, e_seg, e_dp, e_fd}) begin
                miscompares++;
                $display("FAIL free_run i=%0d got an=%b seg=%b fd=%b want an=%b seg=%b fd=%b",
                         i, an, seg, frame_done, e_an, e_seg, e_fd);
            end
            if (frame_done === 1'b1) begin
                if (last >= 0) begin
                    vectors++;
                    if (i - last !== 24) begin
                        miscompares++;
                        $display("FAIL frame_spacing got %0d want 24", i - last);
                    end
                end
                last = i;
                pulses++;
            end
        end
        vectors++;
        if (pulses !== 10) begin
            miscompares++;
            $display("FAIL frame_count got %0d want 10", pulses);
        end
    endtask

    initial begin
        rst = 1'b0;
        bcd_seconds = '0; bcd_minutes = '0; bcd_hours = '0;
        blank = 1'b0; dp_en = 1'b0;
        m_g = 0; m_snap = '0;
        e_an = 3'b111; e_seg = 7'b1111111; e_dp = 1'b1; e_fd = 1'b0;
        test_reset();
        test_scan();
        test_tearing();
        test_dash();
        test_dp_blank();
        test_reset_mid();
        test_free_run();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
